// File: rtl/button_debouncer.sv
// Debounces a raw push-button level: synchronises the pin, then only flips the
// clean output after the new level has been seen for STABLE_CYCLES samples.
module button_debouncer #(
   parameter int SYNC_STAGES   = 2,
   parameter int STABLE_CYCLES = 500,
   parameter int CNT_WIDTH     = 16,
   parameter int GLITCH_WIDTH  = 8
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    raw_in,
   output logic                    debounced,
   output logic                    busy,
   output logic [GLITCH_WIDTH-1:0] glitch_count
);

   localparam logic [CNT_WIDTH-1:0] LAST_COUNT = CNT_WIDTH'(STABLE_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0] CNT_ZERO   = CNT_WIDTH'(0);

   typedef enum logic [1:0] {
      IDLE_LOW  = 2'b00,
      WAIT_HIGH = 2'b01,
      IDLE_HIGH = 2'b10,
      WAIT_LOW  = 2'b11
   } state_t;

   state_t                 state_r;
   logic [SYNC_STAGES-1:0] sync_r;
   logic [CNT_WIDTH-1:0]   count_r;
   logic                   sync_s;

   function automatic logic [GLITCH_WIDTH-1:0] sat_inc(input logic [GLITCH_WIDTH-1:0] value);
      logic [GLITCH_WIDTH-1:0] result;
      if (&value) begin
         result = value;
      end else begin
         result = value + GLITCH_WIDTH'(1);
      end
      return result;
   endfunction

   assign sync_s = sync_r[SYNC_STAGES-1];

   // Metastability chain; only its last stage feeds the FSM.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sync_r <= '0;
      end else begin
         sync_r <= {sync_r[SYNC_STAGES-2:0], raw_in};
      end
   end

   // Qualification FSM; busy and debounced are registered alongside the state.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_r      <= IDLE_LOW;
         count_r      <= CNT_ZERO;
         debounced    <= 1'b0;
         busy         <= 1'b0;
         glitch_count <= '0;
      end else begin
         case (state_r)
            IDLE_LOW: begin
               if (sync_s) begin
                  state_r <= WAIT_HIGH;
                  count_r <= CNT_ONE;
                  busy    <= 1'b1;
               end else begin
                  count_r <= CNT_ZERO;
                  busy    <= 1'b0;
               end
            end
            WAIT_HIGH: begin
               if (!sync_s) begin
                  state_r      <= IDLE_LOW;
                  count_r      <= CNT_ZERO;
                  busy         <= 1'b0;
                  glitch_count <= sat_inc(glitch_count);
               end else if (count_r == LAST_COUNT) begin
                  state_r   <= IDLE_HIGH;
                  count_r   <= CNT_ZERO;
                  busy      <= 1'b0;
                  debounced <= 1'b1;
               end else begin
                  count_r <= count_r + CNT_ONE;
               end
            end
            IDLE_HIGH: begin
               if (!sync_s) begin
                  state_r <= WAIT_LOW;
                  count_r <= CNT_ONE;
                  busy    <= 1'b1;
               end else begin
                  count_r <= CNT_ZERO;
                  busy    <= 1'b0;
               end
            end
            WAIT_LOW: begin
               // Any reversion throws away the partial count; no credit is kept.
               if (sync_s) begin
                  state_r      <= IDLE_HIGH;
                  count_r      <= CNT_ZERO;
                  busy         <= 1'b0;
                  glitch_count <= sat_inc(glitch_count);
               end else if (count_r == LAST_COUNT) begin
                  state_r   <= IDLE_LOW;
                  count_r   <= CNT_ZERO;
                  busy      <= 1'b0;
                  debounced <= 1'b0;
               end else begin
                  count_r <= count_r + CNT_ONE;
               end
            end
            default: begin
               state_r   <= IDLE_LOW;
               count_r   <= CNT_ZERO;
               busy      <= 1'b0;
               debounced <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_button_debouncer.sv
// Directed and randomized checks of button_debouncer against a run-length model
// of the debounce rule, plus a default-parameter instance with a pulse counter.
module tb_button_debouncer;

   localparam int SYNC   = 2;
   localparam int STABLE = 8;
   localparam int CW     = 8;
   localparam int GW     = 4;

   logic          clock   = 1'b0;
   logic          reset   = 1'b0;
   logic          raw_in  = 1'b0;
   logic          raw_def = 1'b0;
   logic          debounced, busy;
   logic [GW-1:0] glitch_count;
   logic          deb_def, busy_def;
   logic [7:0]    glitch_def;
   logic          deb_def_q = 1'b0;
   int            pulses    = 0;

   int   n_cmp = 0;
   int   n_bad = 0;
   logic mq[$];
   int   m_run;
   logic m_deb;
   int   m_glitch;

   always #20 clock = ~clock;

   button_debouncer #(
      .SYNC_STAGES(SYNC), .STABLE_CYCLES(STABLE), .CNT_WIDTH(CW), .GLITCH_WIDTH(GW)
   ) dut (
      .clock(clock), .reset(reset), .raw_in(raw_in),
      .debounced(debounced), .busy(busy), .glitch_count(glitch_count)
   );

   button_debouncer dut_def (
      .clock(clock), .reset(reset), .raw_in(raw_def),
      .debounced(deb_def), .busy(busy_def), .glitch_count(glitch_def)
   );

   // Stand-in for single_pulser: count rising edges of the default instance output.
   always @(posedge clock) begin
      deb_def_q <= deb_def;
      if (deb_def && !deb_def_q) pulses <= pulses + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      for (int i = 0; i < SYNC; i++) mq.push_back(1'b0);
      m_run    = 0;
      m_deb    = 1'b0;
      m_glitch = 0;
   endtask

   task automatic check_all();
      chk("debounced", 32'(debounced), 32'(m_deb));
      chk("busy", 32'(busy), 32'(m_run != 0));
      chk("glitch_count", 32'(glitch_count), 32'(m_glitch));
   endtask

   // One clock with raw_in = r; the model sees the pin SYNC edges late and
   // flips only after STABLE consecutive differing samples.
   task automatic step(input logic r);
      logic v;
      raw_in = r;
      @(posedge clock);
      v = mq.pop_front();
      mq.push_back(r);
      if (v != m_deb) begin
         m_run++;
         if (m_run == STABLE) begin
            m_deb = v;
            m_run = 0;
         end
      end else begin
         if (m_run != 0 && m_glitch < (1 << GW) - 1) m_glitch++;
         m_run = 0;
      end
      #1 check_all();
   endtask

   task automatic do_reset(input logic r);
      raw_in = r;
      reset  = 1'b0;
      model_reset();
      #1 check_all();
      for (int i = 0; i < 2; i++) begin
         @(posedge clock);
         #1 check_all();
      end
      reset = 1'b1;
   endtask

   initial begin
      int   rise_k, busy_k, toggles, g0, lvl_i;
      logic prev;

      // Reset and idle
      do_reset(1'b0);
      for (int i = 0; i < 50; i++) step(1'b0);

      // Clean press: busy at edge 3, debounced at edge 10
      rise_k = 0; busy_k = 0;
      for (int k = 1; k <= 14; k++) begin
         step(1'b1);
         if (busy && busy_k == 0) busy_k = k;
         if (debounced && rise_k == 0) rise_k = k;
      end
      chk("clean_busy_edge", 32'(busy_k), 32'd3);
      chk("clean_rise_edge", 32'(rise_k), 32'd10);
      chk("clean_glitch", 32'(glitch_count), 32'd0);
      for (int i = 0; i < 14; i++) step(1'b0);

      // Bounced press
      g0 = int'(glitch_count);
      toggles = 0; prev = debounced;
      for (int i = 0; i < 4; i++) begin
         step(1'b1); step(1'b1); step(1'b0); step(1'b0);
         if (i == 1) break;
      end
      rise_k = 0;
      for (int k = 1; k <= 14; k++) begin
         step(1'b1);
         if (debounced !== prev) toggles++;
         prev = debounced;
         if (debounced && rise_k == 0) rise_k = k;
      end
      chk("bounce_glitch_delta", 32'(int'(glitch_count) - g0), 32'd2);
      chk("bounce_rise_edge", 32'(rise_k), 32'd10);
      chk("bounce_toggles", 32'(toggles), 32'd1);
      for (int i = 0; i < 14; i++) step(1'b0);

      // Short pulse rejection
      g0 = int'(glitch_count);
      for (int i = 0; i < 5; i++) step(1'b1);
      for (int i = 0; i < 14; i++) step(1'b0);
      chk("short_glitch_delta", 32'(int'(glitch_count) - g0), 32'd1);
      chk("short_debounced", 32'(debounced), 32'd0);

      // Reset in the middle of a release qualification
      for (int i = 0; i < 12; i++) step(1'b1);
      for (int i = 0; i < 6; i++) step(1'b0);
      chk("mid_busy_before", 32'(busy), 32'd1);
      chk("mid_deb_before", 32'(debounced), 32'd1);
      reset = 1'b0;
      #1;
      chk("mid_deb_reset", 32'(debounced), 32'd0);
      chk("mid_busy_reset", 32'(busy), 32'd0);
      chk("mid_glitch_reset", 32'(glitch_count), 32'd0);
      do_reset(1'b0);
      for (int i = 0; i < 20; i++) step(1'b0);

      // Randomized segments; glitch_count saturates along the way
      lvl_i = 0;
      for (int i = 0; i < 250; i++) begin
         int len;
         len = int'($urandom_range(1, 12));
         lvl_i = 1 - lvl_i;
         for (int j = 0; j < len; j++) step(lvl_i[0]);
      end
      for (int i = 0; i < 14; i++) step(lvl_i[0]);
      chk("rand_glitch_sat", 32'(glitch_count), 32'((1 << GW) - 1));

      // raw_in already high when reset releases
      do_reset(1'b1);
      rise_k = 0;
      for (int k = 1; k <= 14; k++) begin
         step(1'b1);
         if (debounced && rise_k == 0) rise_k = k;
      end
      chk("high_at_release_rise", 32'(rise_k), 32'd10);

      // Default parameters with downstream pulse counter
      do_reset(1'b0);
      for (int i = 0; i < 4; i++) step(1'b0);
      chk("def_pulses_idle", 32'(pulses), 32'd0);
      raw_def = 1'b1;
      rise_k = 0;
      for (int k = 1; k <= 2000; k++) begin
         @(posedge clock);
         #1;
         if (deb_def && rise_k == 0) rise_k = k;
      end
      chk("def_rise_edge", 32'(rise_k), 32'd502);
      chk("def_high_hold", 32'(deb_def), 32'd1);
      raw_def = 1'b0;
      for (int k = 0; k < 600; k++) begin
         @(posedge clock);
         #1;
      end
      chk("def_released", 32'(deb_def), 32'd0);
      chk("def_pulse_count", 32'(pulses), 32'd1);
      chk("def_glitch", 32'(glitch_def), 32'd0);
      chk("def_busy", 32'(busy_def), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
